alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data path width in bits (legal values 8..64, power of two).
REQ-002 SHALL provide parameter SHW, default $clog2(WIDTH), shift-amount field width.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  operand/op presented.
REQ-006 SHALL provide port in_ready  output  1  block can accept an operation.
REQ-007 SHALL provide port ctl  input  4  opcode.
REQ-008 SHALL provide ports a, b  input  WIDTH  operands.
REQ-009 SHALL provide port out_valid  output  1  result held and valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port result  output  WIDTH  registered result.
REQ-012 SHALL provide ports zero, ovf, err  output  1 each  registered flags.

Function
REQ-013 SHALL decode ctl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0101 SLL, 0011 SRL, 0100 SRA, 1000 XOR, 1001 NOR, 1010 SLTU, 1100 MUL (low half), 1101 MULHU (high half, unsigned), 1110 DIVU, 1111 REMU; 1011 undefined.
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept (handshake) when in_valid & in_ready on a rising edge; capture ctl, a, b at that edge.
REQ-016 Single-cycle ops (all except MUL/MULHU/DIVU/REMU): IDLE -> DONE on accept; out_valid high on the cycle after accept (latency 1).
REQ-017 Iterative ops: IDLE -> BUSY on accept; one radix-2 step per cycle for exactly WIDTH cycles; BUSY -> DONE after last step; out_valid high WIDTH+1 cycles after accept.
REQ-018 MUL/MULHU SHALL use unsigned shift-add producing a 2*WIDTH product; MUL returns bits [WIDTH-1:0], MULHU bits [2*WIDTH-1:WIDTH].
REQ-019 DIVU/REMU SHALL use unsigned restoring division; b = 0 -> DIVU result all-ones, REMU result = a, ovf = 1; still takes WIDTH+1 cycles.
REQ-020 Shifts SHALL use only b[SHW-1:0] as amount; upper bits of b ignored.
REQ-021 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH.
REQ-022 ovf SHALL be: ADD/SUB signed two's-complement overflow; MUL high half nonzero; DIVU/REMU divide-by-zero; 0 otherwise.
REQ-023 zero SHALL equal (result == 0), registered with result.
REQ-024 Undefined opcode SHALL complete as single-cycle op with result = 0, err = 1, zero = 1, ovf = 0; err = 0 for all defined opcodes.
REQ-025 In DONE, result and flags SHALL hold stable while out_ready = 0; DONE -> IDLE on out_ready = 1.
REQ-026 in_valid and operand changes during BUSY or DONE SHALL be ignored (in_ready = 0).
REQ-027 Throughput SHALL be one op per 2 cycles (single-cycle ops, out_ready held 1), one per WIDTH+2 cycles (iterative).

Reset
REQ-028 rst = 1 at an edge SHALL force state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 0, ovf = 0, err = 0, iteration counter = 0.
REQ-029 rst SHALL take priority over accept, iteration and release; rst mid-BUSY SHALL abandon the op with no out_valid pulse.
REQ-030 First accept SHALL be possible on the first edge with rst = 0.

Verification (WIDTH = 32)
REQ-031 ADD a=0x7FFFFFFF b=0x00000001 -> next cycle out_valid=1, result=0x80000000, ovf=1, zero=0, err=0.
REQ-032 MUL a=0x00010000 b=0x00010000 -> out_valid exactly 33 cycles after accept, result=0x00000000, zero=1, ovf=1; MULHU same operands -> 0x00000001.
REQ-033 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x5/0 -> 0xFFFFFFFF, ovf=1; REMU 0x5/0 -> 0x5, ovf=1.
REQ-034 SLT a=0xFFFFFFFF b=1 -> 1; SLTU same -> 0; SLL a=1 b=0x21 -> 0x2; SRA a=0x80000000 b=4 -> 0xF8000000.
REQ-035 Hold out_ready=0 for 10 cycles after ADD completes, toggle a/b/in_valid -> result, flags, out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst at cycle 10 of a DIVU -> next cycle in_ready=1, out_valid=0, result=0; opcode 1011 -> result=0, err=1, zero=1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative shift-add
// multiply and restoring divide, behind a valid/ready handshake on both sides.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SRL   = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             ovf_reg, ovf_next;
    logic             err_reg, err_next;

    // Single-cycle datapath, evaluated directly on the presented operands
    logic [WIDTH-1:0] sum, dif;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_err, alu_iter;

    always_comb begin
        sum      = a + b;
        dif      = a - b;
        shamt    = b[SHW-1:0];
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        alu_iter = 1'b0;
        case (ctl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_iter = 1'b1;
            default: alu_err = 1'b1;
        endcase
    end

    // One radix-2 step. Multiply: {hi,lo} holds partial product / multiplier.
    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   rem_shift;
    logic             div_take;
    logic [WIDTH-1:0] div_sub, div_hi, div_lo;
    logic [WIDTH-1:0] iter_res;
    logic             iter_ovf;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(WIDTH+1){1'b0}});
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo_reg[WIDTH-1:1]};
        rem_shift = {hi_reg, lo_reg[WIDTH-1]};
        // A zero divisor always "takes", so quotient becomes all-ones and the
        // remainder ends up holding the original dividend.
        div_take  = (rem_shift >= {1'b0, b_reg});
        div_sub   = rem_shift[WIDTH-1:0] - b_reg;
        div_hi    = div_take ? div_sub : rem_shift[WIDTH-1:0];
        div_lo    = {lo_reg[WIDTH-2:0], div_take};
        iter_res  = '0;
        iter_ovf  = 1'b0;
        case (op_reg)
            2'b00: begin
                iter_res = mul_lo;
                iter_ovf = |mul_hi;
            end
            2'b01: iter_res = mul_hi;
            2'b10: begin
                iter_res = div_lo;
                iter_ovf = (b_reg == '0);
            end
            default: begin
                iter_res = div_hi;
                iter_ovf = (b_reg == '0);
            end
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        err_next    = err_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (alu_iter) begin
                        state_next = BUSY;
                        op_next    = ctl[1:0];
                        hi_next    = '0;
                        lo_next    = a;
                        b_next     = b;
                        cnt_next   = '0;
                    end else begin
                        state_next  = DONE;
                        result_next = alu_res;
                        zero_next   = (alu_res == '0);
                        ovf_next    = alu_ovf;
                        err_next    = alu_err;
                    end
                end
            end
            BUSY: begin
                hi_next  = op_reg[1] ? div_hi : mul_hi;
                lo_next  = op_reg[1] ? div_lo : mul_lo;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == SHW'(WIDTH-1)) begin
                    state_next  = DONE;
                    cnt_next    = '0;
                    result_next = iter_res;
                    zero_next   = (iter_res == '0);
                    ovf_next    = iter_ovf;
                    err_next    = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
            err_reg    <= err_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign ovf       = ovf_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed + randomised bench for alu_mc (WIDTH=32) with an expected-result queue.
module tb_alu_mc;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ctl;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero, ovf, err;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctl       (ctl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic z, input logic o,
                                input logic e, input int lat);
        exp_t t;
        t.res = r; t.z = z; t.o = o; t.e = e; t.lat = lat;
        return t;
    endfunction

    // Reference behaviour using plain wide arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        longint      s;
        logic [63:0] p;
        r = mk(32'h0, 1'b0, 1'b0, 1'b0, 1);
        p = 64'(x) * 64'(y);
        case (op)
            4'b0000: r.res = x & y;
            4'b0001: r.res = x | y;
            4'b1000: r.res = x ^ y;
            4'b1001: r.res = ~(x | y);
            4'b0010: begin
                s = longint'($signed(x)) + longint'($signed(y));
                r.res = s[31:0];
                r.o = (s != longint'($signed(r.res)));
            end
            4'b0110: begin
                s = longint'($signed(x)) - longint'($signed(y));
                r.res = s[31:0];
                r.o = (s != longint'($signed(r.res)));
            end
            4'b0111: r.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1010: r.res = (x < y) ? 32'd1 : 32'd0;
            4'b0101: r.res = x << y[4:0];
            4'b0011: r.res = x >> y[4:0];
            4'b0100: r.res = $signed(x) >>> y[4:0];
            4'b1100: begin r.res = p[31:0];  r.o = (p[63:32] != 0); r.lat = 33; end
            4'b1101: begin r.res = p[63:32]; r.lat = 33; end
            4'b1110: begin
                r.res = (y == 0) ? 32'hFFFF_FFFF : x / y;
                r.o = (y == 0); r.lat = 33;
            end
            4'b1111: begin
                r.res = (y == 0) ? x : x % y;
                r.o = (y == 0); r.lat = 33;
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 0);
        return r;
    endfunction

    // Present one op, scramble inputs while it runs, then check and release it
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input exp_t ex);
        exp_t got;
        int   lat;
        sb.push_back(ex);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; ctl = op; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            ctl = 4'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        got = sb.pop_front();
        chk({tag, ".lat"},    64'(lat),    64'(got.lat));
        chk({tag, ".result"}, 64'(result), 64'(got.res));
        chk({tag, ".flags"},  64'({zero, ovf, err}), 64'({got.z, got.o, got.e}));
        $display("op %s ctl=%b a=%h b=%h -> result=%h z=%0b o=%0b e=%0b lat=%0d",
                 tag, op, x, y, result, zero, ovf, err, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release"}, 64'({in_ready, out_valid}), 64'b10);
    endtask

    logic [3:0] ops [15] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                             4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b1110,
                             4'b1111};

    initial begin
        exp_t ex;
        int   acc;
        int   pulses;
        logic [3:0]  op;
        logic [31:0] x, y;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ctl = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.hs",     64'({in_ready, out_valid}), 64'b10);
        chk("reset.result", 64'(result), 64'd0);
        chk("reset.flags",  64'({zero, ovf, err}), 64'b000);
        rst = 1'b0;

        // Accepted on the first edge with reset low
        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 0, 1, 0, 1));
        run_op("mul",     4'b1100, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 1, 1, 0, 33));
        run_op("mulhu",   4'b1101, 32'h0001_0000, 32'h0001_0000, mk(32'h1, 0, 0, 0, 33));
        run_op("divu",    4'b1110, 32'd100, 32'd7, mk(32'd14, 0, 0, 0, 33));
        run_op("remu",    4'b1111, 32'd100, 32'd7, mk(32'd2, 0, 0, 0, 33));
        run_op("divu0",   4'b1110, 32'h5, 32'h0, mk(32'hFFFF_FFFF, 0, 1, 0, 33));
        run_op("remu0",   4'b1111, 32'h5, 32'h0, mk(32'h5, 0, 1, 0, 33));
        run_op("slt",     4'b0111, 32'hFFFF_FFFF, 32'h1, mk(32'h1, 0, 0, 0, 1));
        run_op("sltu",    4'b1010, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 1, 0, 0, 1));
        run_op("sll",     4'b0101, 32'h1, 32'h21, mk(32'h2, 0, 0, 0, 1));
        run_op("sra",     4'b0100, 32'h8000_0000, 32'h4, mk(32'hF800_0000, 0, 0, 0, 1));
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 0, 1, 0, 1));
        run_op("nor",     4'b1001, 32'hF0F0_0000, 32'h0F0F_0000, mk(32'h0000_FFFF, 0, 0, 0, 1));

        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 14)];
            x = $urandom; y = $urandom;
            if (i % 4 == 3) y = y >> $urandom_range(20, 31);
            run_op("rnd", op, x, y, model(op, x, y));
        end

        // Result and flags held while the consumer stalls
        sb.push_back(mk(32'h8000_0000, 0, 1, 0, 1));
        in_valid = 1'b1; ctl = 4'b0010; a = 32'h7FFF_FFFF; b = 32'h1;
        @(posedge clk); #1;
        ex = sb.pop_front();
        chk("hold.valid0", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            ctl = 4'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            chk("hold.result", 64'(result), 64'(ex.res));
            chk("hold.state",  64'({out_valid, in_ready, zero, ovf, err}),
                               64'({1'b1, 1'b0, ex.z, ex.o, ex.e}));
        end
        $display("op hold-10 result=%h ovf=%0b out_valid=%0b", result, ovf, out_valid);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold.release", 64'({in_ready, out_valid}), 64'b10);

        // Reset during a divide abandons it
        in_valid = 1'b1; ctl = 4'b1110; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("abort.busy", 64'({in_ready, out_valid}), 64'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.hs",     64'({in_ready, out_valid}), 64'b10);
        chk("abort.result", 64'(result), 64'd0);
        chk("abort.flags",  64'({zero, ovf, err}), 64'b000);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("abort.no_valid", 64'(pulses), 64'd0);
        $display("op abort-divu result=%h pulses=%0d", result, pulses);

        run_op("undef", 4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0, 1, 0, 1, 1));

        // Back-to-back throughput
        acc = 0;
        in_valid = 1'b1; ctl = 4'b0001; a = 32'h5; b = 32'h3; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("tput.single", 64'(acc), 64'd10);
        $display("op tput-single accepts=%0d in 20 cycles", acc);
        acc = 0;
        ctl = 4'b1100;
        for (int i = 0; i < 68; i++) begin
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("tput.iter", 64'(acc), 64'd2);
        $display("op tput-iter accepts=%0d in 68 cycles", acc);
        in_valid = 1'b0; out_ready = 1'b0;

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
